// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encodings
// and default parameter values.
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_ZEXT8  = 2'd0,
    IMM_ZEXT12 = 2'd1,
    IMM_BRANCH = 2'd2,
    IMM_ROT8   = 2'd3
  } imm_mode_e;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_INSTR_W      = 24;
  localparam int DEF_OFFSET_SHIFT = 2;

endpackage

// File: rtl/imm_rotator.sv
// Combinational rotate-right of a DATA_W word by twice a 4-bit amount.
module imm_rotator #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        half_amt,
  output logic [DATA_W-1:0] rotated
);

  logic [31:0]         amt;
  logic [2*DATA_W-1:0] doubled;

  // Rotating the doubled word right keeps wrapped bits in the low half.
  always_comb begin
    amt     = 32'({half_amt, 1'b0}) % 32'(DATA_W);
    doubled = {data, data};
    rotated = DATA_W'(doubled >> amt);
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage (capture, extend) immediate extension pipeline with valid/ready
// handshakes. Mode 3 (rotated immediate) exists only when IMM_ROTATE_EN is defined.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int INSTR_W      = DEF_INSTR_W,
  parameter int OFFSET_SHIFT = DEF_OFFSET_SHIFT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [1:0]         imm_src,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  ext_imm,
  output logic               illegal
);

  if (DATA_W < INSTR_W + OFFSET_SHIFT || DATA_W < 12 || INSTR_W < 12) begin : g_bad_params
    $fatal(1, "imm_extend_pipe: need DATA_W >= INSTR_W+OFFSET_SHIFT, DATA_W >= 12, INSTR_W >= 12");
  end

  logic               s1_valid;
  logic [INSTR_W-1:0] s1_instr;
  imm_mode_e          s1_mode;
  logic               s2_advance;
  logic [DATA_W-1:0]  sext;
  logic [DATA_W-1:0]  ext_next;
  logic               illegal_next;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_mode  <= IMM_ZEXT8;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_instr <= instr;
        s1_mode  <= imm_mode_e'(imm_src);
      end
    end
  end

`ifdef IMM_ROTATE_EN
  logic [DATA_W-1:0] rot_out;

  imm_rotator #(.DATA_W(DATA_W)) u_rotator (
    .data     (DATA_W'(s1_instr[7:0])),
    .half_amt (s1_instr[11:8]),
    .rotated  (rot_out)
  );
`endif

  always_comb begin
    ext_next     = '0;
    illegal_next = 1'b0;
    sext         = DATA_W'($signed(s1_instr));
    case (s1_mode)
      IMM_ZEXT8:  ext_next = DATA_W'(s1_instr[7:0]);
      IMM_ZEXT12: ext_next = DATA_W'(s1_instr[11:0]);
      IMM_BRANCH: ext_next = sext << OFFSET_SHIFT;
      IMM_ROT8: begin
`ifdef IMM_ROTATE_EN
        ext_next = rot_out;
`else
        illegal_next = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Output registers only move when downstream has taken the current word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ext_imm   <= '0;
      illegal   <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        ext_imm <= ext_next;
        illegal <= illegal_next;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe; expectations for mode 3
// follow whether IMM_ROTATE_EN is defined.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] instr;
  logic [1:0]  imm_src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ext_imm;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  imm_extend_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .imm_src   (imm_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ext_imm   (ext_imm),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the pipeline empty and out_ready high.
  task automatic send_one(input string tag, input logic [1:0] src, input logic [23:0] ins,
                          input logic [31:0] exp_imm, input logic exp_ill);
    in_valid = 1'b1;
    imm_src  = src;
    instr    = ins;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({tag, "_valid_c1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, "_valid_c2"}, 32'(out_valid), 32'd1);
    chk({tag, "_imm"}, ext_imm, exp_imm);
    chk({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
    @(negedge clk);
  endtask

  logic [1:0]  bp_src [4];
  logic [23:0] bp_ins [4];
  logic [31:0] bp_exp [4];

  initial begin
    int sent;
    int got;
    logic saw_drop;
    logic prev_stall;
    logic [31:0] prev_imm;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    imm_src   = 2'd0;
    instr     = '0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ext_imm", ext_imm, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send_one("m0_a5", 2'd0, 24'h0000A5, 32'h000000A5, 1'b0);
    send_one("m0_high", 2'd0, 24'hFFFF5A, 32'h0000005A, 1'b0);
    send_one("m1_123", 2'd1, 24'hABC123, 32'h00000123, 1'b0);
    send_one("m2_neg", 2'd2, 24'h800001, 32'hFE000004, 1'b0);
    send_one("m2_pos", 2'd2, 24'h000003, 32'h0000000C, 1'b0);
    send_one("m2_m1", 2'd2, 24'hFFFFFF, 32'hFFFFFFFC, 1'b0);
`ifdef IMM_ROTATE_EN
    send_one("m3_1ff", 2'd3, 24'h0001FF, 32'hC000003F, 1'b0);
    send_one("m3_rot0", 2'd3, 24'h0000AB, 32'h000000AB, 1'b0);
    send_one("m3_rot30", 2'd3, 24'h000F80, 32'h00000200, 1'b0);
`else
    send_one("m3_1ff", 2'd3, 24'h0001FF, 32'h00000000, 1'b1);
    send_one("m3_f80", 2'd3, 24'h000F80, 32'h00000000, 1'b1);
`endif

    // Back-to-back stream with a 3-cycle downstream stall.
    bp_src = '{2'd0, 2'd1, 2'd0, 2'd2};
    bp_ins = '{24'h000011, 24'h000222, 24'h000033, 24'h000005};
    bp_exp = '{32'h00000011, 32'h00000222, 32'h00000033, 32'h00000014};
    sent = 0;
    got = 0;
    saw_drop = 1'b0;
    prev_stall = 1'b0;
    prev_imm = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 4);
      if (sent < 4) begin
        imm_src = bp_src[sent];
        instr   = bp_ins[sent];
      end
      #1;
      if (prev_stall) begin
        chk("bp_stall_valid", 32'(out_valid), 32'd1);
        chk("bp_stall_imm", ext_imm, prev_imm);
      end
      if (in_valid && !in_ready) saw_drop = 1'b1;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_out%0d", got), ext_imm, bp_exp[got]);
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_imm   = ext_imm;
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 32'(got), 32'd4);
    chk("bp_in_ready_drop", 32'(saw_drop), 32'd1);
    #1;
    chk("bp_no_extra", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Reset while two items are in flight.
    in_valid = 1'b1;
    imm_src  = 2'd0;
    instr    = 24'h000001;
    @(negedge clk);
    instr    = 24'h000002;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_imm", ext_imm, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst_idle%0d", i), 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    send_one("post_rst", 2'd1, 24'h000ABC, 32'h00000ABC, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; its ports SHALL be named clk and rst_n.
REQ-002 Parameter DATA_W, default 32: width of the extended immediate.
REQ-003 Parameter INSTR_W, default 24: width of the instruction field input.
REQ-004 Parameter OFFSET_SHIFT, default 2: left shift applied to branch offsets.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port in_valid, input, 1: the instr/imm_src pair is valid.
REQ-008 Port in_ready, output, 1: the block accepts the input this cycle.
REQ-009 Port instr, input, INSTR_W: instruction immediate field.
REQ-010 Port imm_src, input, 2: extension mode.
REQ-011 Port out_valid, output, 1: ext_imm and illegal are valid.
REQ-012 Port out_ready, input, 1: downstream accepts the output.
REQ-013 Port ext_imm, output, DATA_W: extended immediate.
REQ-014 Port illegal, output, 1: the mode is not supported in this build.

Function
REQ-015 The datapath SHALL have two register stages, S1 (capture) and S2 (extend/output), giving a latency of 2 cycles from input transfer to out_valid when there is no stall.
REQ-016 A transfer SHALL occur on a rising edge when valid and ready are both high; throughput SHALL be 1 per cycle while out_ready is held high.
REQ-017 Backpressure: S2 SHALL hold when out_valid=1 and out_ready=0; S1 SHALL advance only when S2 is empty or draining; in_ready SHALL be !s1_valid || s2_advance.
REQ-018 On a stall, no accepted item SHALL be lost or duplicated, and output order SHALL equal input order.
REQ-019 ext_imm and illegal SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 Mode 0 SHALL produce zero-extend(instr[7:0]).
REQ-021 Mode 1 SHALL produce zero-extend(instr[11:0]).
REQ-022 Mode 2 SHALL produce sign-extend(instr[INSTR_W-1:0]) << OFFSET_SHIFT, truncated to DATA_W, with sign bit instr[INSTR_W-1].
REQ-023 Mode 3 (rotated immediate) SHALL produce zero-extend(instr[7:0]) rotated right by 2*instr[11:8] within DATA_W.
REQ-024 A mode that is not built in SHALL give ext_imm=0 and illegal=1; every other mode SHALL give illegal=0.
REQ-025 DATA_W >= INSTR_W+OFFSET_SHIFT and DATA_W >= 12 SHALL be checked at elaboration; a violation SHALL be a fatal error.

Reset
REQ-026 While rst_n=0: s1_valid=0, out_valid=0, ext_imm=0, illegal=0, in_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard in-flight items; the first accept after rst_n deasserts SHALL appear at the output 2 cycles later.

Configuration
REQ-028 Macro IMM_ROTATE_EN defined: mode 3 SHALL implement REQ-023 through the rotator sub-module.
REQ-029 Macro IMM_ROTATE_EN undefined: the rotator SHALL not be instantiated, and mode 3 SHALL follow REQ-024 (ext_imm=0, illegal=1).

Structure
REQ-030 Package imm_pkg SHALL hold the mode encodings IMM_ZEXT8=0, IMM_ZEXT12=1, IMM_BRANCH=2, IMM_ROT8=3, the mode typedef, and the default parameter constants.
REQ-031 Sub-module imm_rotator (combinational, DATA_W-parameterised rotate-right by an even amount) SHALL be the only sub-module.

Verification
REQ-032 Mode 0, instr=0x0000A5 -> ext_imm=0x000000A5, illegal=0, out_valid exactly 2 cycles after accept.
REQ-033 Mode 1, instr=0xABC123 -> 0x00000123.
REQ-034 Mode 2, instr=0x800001 -> 0xFE000004; instr=0x000003 -> 0x0000000C.
REQ-035 Mode 3, instr=0x0001FF -> 0xC000003F with IMM_ROTATE_EN defined; -> 0x00000000 with illegal=1 when it is undefined.
REQ-036 Back-to-back input of 4 items with out_ready low for 3 cycles mid-stream -> in_ready drops, all 4 outputs arrive in order with no loss or duplication, and ext_imm stays stable during the stall.
REQ-037 rst_n pulsed low while 2 items are in flight -> out_valid=0 immediately, no stale output afterwards, and the next item has 2-cycle latency.
